// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register of the 8-bit pipelined core.
// Resolves operands through EX/MEM and MEM/WB forwarding, runs the ALU, owns
// the carry/zero flag registers and registers result plus control for MEM.
module ex_mem_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INSTR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [DATA_W-1:0]  ID_EX_A,
  input  logic [DATA_W-1:0]  ID_EX_B,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic               ID_EX_mem_write,
  input  logic               ID_EX_reg_write,
  input  logic               ID_EX_alu_use_carry,
  input  logic               ID_EX_alu_B_mux,
  input  logic               ID_EX_select_c,
  input  logic               ID_EX_select_z,
  input  logic               ID_EX_write_c,
  input  logic               ID_EX_write_z,
  input  logic [2:0]         ID_EX_alu_op,
  input  logic [1:0]         ID_EX_reg_write_mux,
  input  logic               MEM_WB_reg_write,
  input  logic [2:0]         MEM_WB_dest,
  input  logic [DATA_W-1:0]  MEM_WB_data,
  output logic [DATA_W-1:0]  EX_MEM_alu_result,
  output logic [DATA_W-1:0]  EX_MEM_B,
  output logic [INSTR_W-1:0] EX_MEM_instruction,
  output logic [2:0]         EX_MEM_dest,
  output logic               EX_MEM_mem_write,
  output logic               EX_MEM_reg_write,
  output logic               EX_MEM_select_c,
  output logic               EX_MEM_select_z,
  output logic [1:0]         EX_MEM_reg_write_mux,
  output logic               flag_c,
  output logic               flag_z
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpShl  = 3'b101;
  localparam logic [2:0] OpShr  = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  localparam logic [1:0] WbAlu = 2'b00;

  logic [2:0]        dest;
  logic [2:0]        src_a;
  logic [2:0]        src_b;
  logic [DATA_W-1:0] imm;

  assign dest  = ID_EX_instruction[13:11];
  assign src_a = ID_EX_instruction[10:8];
  assign src_b = ID_EX_instruction[7:5];
  assign imm   = ID_EX_instruction[DATA_W-1:0];

  // Only ALU results can be forwarded from EX/MEM; a load's data does not
  // exist yet, so load-use hazards must be stalled upstream.
  logic exmem_fwd_ok;
  assign exmem_fwd_ok = EX_MEM_reg_write && (EX_MEM_reg_write_mux == WbAlu);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Operand A forwarding: EX/MEM beats MEM/WB beats register file.
  always_comb begin
    fwd_a = ID_EX_A;
    if (exmem_fwd_ok && (EX_MEM_dest == src_a)) begin
      fwd_a = EX_MEM_alu_result;
    end else if (MEM_WB_reg_write && (MEM_WB_dest == src_a)) begin
      fwd_a = MEM_WB_data;
    end
  end

  // Operand B forwarding: same priority as A, compared against srcB.
  always_comb begin
    fwd_b = ID_EX_B;
    if (exmem_fwd_ok && (EX_MEM_dest == src_b)) begin
      fwd_b = EX_MEM_alu_result;
    end else if (MEM_WB_reg_write && (MEM_WB_dest == src_b)) begin
      fwd_b = MEM_WB_data;
    end
  end

  logic [DATA_W-1:0] op_b;
  logic              cin;

  assign op_b = ID_EX_alu_B_mux ? imm : fwd_b;
  assign cin  = ID_EX_alu_use_carry & flag_c;

  logic [DATA_W:0]   alu_wide;
  logic              alu_c;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z;

  // ALU in DATA_W+1 bits so the top bit of ADD/SUB is the carry/borrow.
  always_comb begin
    alu_wide = '0;
    alu_c    = 1'b0;
    case (ID_EX_alu_op)
      OpAdd: begin
        alu_wide = {1'b0, fwd_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
        alu_c    = alu_wide[DATA_W];
      end
      OpSub: begin
        alu_wide = {1'b0, fwd_a} - {1'b0, op_b} - {{DATA_W{1'b0}}, cin};
        alu_c    = alu_wide[DATA_W];
      end
      OpAnd:  alu_wide = {1'b0, fwd_a & op_b};
      OpOr:   alu_wide = {1'b0, fwd_a | op_b};
      OpXor:  alu_wide = {1'b0, fwd_a ^ op_b};
      OpShl: begin
        alu_wide = {1'b0, fwd_a[DATA_W-2:0], cin};
        alu_c    = fwd_a[DATA_W-1];
      end
      OpShr: begin
        alu_wide = {1'b0, cin, fwd_a[DATA_W-1:1]};
        alu_c    = fwd_a[0];
      end
      OpPass: alu_wide = {1'b0, op_b};
      default: begin
        alu_wide = '0;
        alu_c    = 1'b0;
      end
    endcase
  end

  assign alu_res = alu_wide[DATA_W-1:0];
  assign alu_z   = (alu_res == '0);

  // Flag registers; written back-to-back so the next EX instruction sees them.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (!stall) begin
      if (ID_EX_write_c) flag_c <= alu_c;
      if (ID_EX_write_z) flag_z <= alu_z;
    end
  end

  // EX/MEM pipeline register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      EX_MEM_alu_result    <= '0;
      EX_MEM_B             <= '0;
      EX_MEM_instruction   <= '0;
      EX_MEM_dest          <= '0;
      EX_MEM_mem_write     <= 1'b0;
      EX_MEM_reg_write     <= 1'b0;
      EX_MEM_select_c      <= 1'b0;
      EX_MEM_select_z      <= 1'b0;
      EX_MEM_reg_write_mux <= '0;
    end else if (!stall) begin
      EX_MEM_alu_result    <= alu_res;
      EX_MEM_B             <= fwd_b;
      EX_MEM_instruction   <= ID_EX_instruction;
      EX_MEM_dest          <= dest;
      EX_MEM_mem_write     <= ID_EX_mem_write;
      EX_MEM_reg_write     <= ID_EX_reg_write;
      EX_MEM_select_c      <= ID_EX_select_c;
      EX_MEM_select_z      <= ID_EX_select_z;
      EX_MEM_reg_write_mux <= ID_EX_reg_write_mux;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the registered outputs.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [7:0]  ID_EX_A;
  logic [7:0]  ID_EX_B;
  logic [18:0] ID_EX_instruction;
  logic        ID_EX_mem_write;
  logic        ID_EX_reg_write;
  logic        ID_EX_alu_use_carry;
  logic        ID_EX_alu_B_mux;
  logic        ID_EX_select_c;
  logic        ID_EX_select_z;
  logic        ID_EX_write_c;
  logic        ID_EX_write_z;
  logic [2:0]  ID_EX_alu_op;
  logic [1:0]  ID_EX_reg_write_mux;
  logic        MEM_WB_reg_write;
  logic [2:0]  MEM_WB_dest;
  logic [7:0]  MEM_WB_data;
  logic [7:0]  EX_MEM_alu_result;
  logic [7:0]  EX_MEM_B;
  logic [18:0] EX_MEM_instruction;
  logic [2:0]  EX_MEM_dest;
  logic        EX_MEM_mem_write;
  logic        EX_MEM_reg_write;
  logic        EX_MEM_select_c;
  logic        EX_MEM_select_z;
  logic [1:0]  EX_MEM_reg_write_mux;
  logic        flag_c;
  logic        flag_z;

  ex_mem_stage #(.DATA_W(8), .INSTR_W(19)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .ID_EX_A              (ID_EX_A),
    .ID_EX_B              (ID_EX_B),
    .ID_EX_instruction    (ID_EX_instruction),
    .ID_EX_mem_write      (ID_EX_mem_write),
    .ID_EX_reg_write      (ID_EX_reg_write),
    .ID_EX_alu_use_carry  (ID_EX_alu_use_carry),
    .ID_EX_alu_B_mux      (ID_EX_alu_B_mux),
    .ID_EX_select_c       (ID_EX_select_c),
    .ID_EX_select_z       (ID_EX_select_z),
    .ID_EX_write_c        (ID_EX_write_c),
    .ID_EX_write_z        (ID_EX_write_z),
    .ID_EX_alu_op         (ID_EX_alu_op),
    .ID_EX_reg_write_mux  (ID_EX_reg_write_mux),
    .MEM_WB_reg_write     (MEM_WB_reg_write),
    .MEM_WB_dest          (MEM_WB_dest),
    .MEM_WB_data          (MEM_WB_data),
    .EX_MEM_alu_result    (EX_MEM_alu_result),
    .EX_MEM_B             (EX_MEM_B),
    .EX_MEM_instruction   (EX_MEM_instruction),
    .EX_MEM_dest          (EX_MEM_dest),
    .EX_MEM_mem_write     (EX_MEM_mem_write),
    .EX_MEM_reg_write     (EX_MEM_reg_write),
    .EX_MEM_select_c      (EX_MEM_select_c),
    .EX_MEM_select_z      (EX_MEM_select_z),
    .EX_MEM_reg_write_mux (EX_MEM_reg_write_mux),
    .flag_c               (flag_c),
    .flag_z               (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  res;
    logic [7:0]  b;
    logic [18:0] instr;
    logic [2:0]  dest;
    logic [5:0]  ctl;
    logic        fc;
    logic        fz;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  function automatic logic [18:0] mk(input logic [2:0] d, input logic [2:0] sa,
                                     input logic [7:0] low);
    return {5'b0, d, sa, low};
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, nm, act, want);
    end
  endtask

  // Monitor: every negedge with a pending expectation, compare all outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("alu_result", e.id, 32'(EX_MEM_alu_result), 32'(e.res));
      chk("B", e.id, 32'(EX_MEM_B), 32'(e.b));
      chk("instruction", e.id, 32'(EX_MEM_instruction), 32'(e.instr));
      chk("dest", e.id, 32'(EX_MEM_dest), 32'(e.dest));
      chk("ctl", e.id, 32'({EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_select_c,
                            EX_MEM_select_z, EX_MEM_reg_write_mux}), 32'(e.ctl));
      chk("flag_c", e.id, 32'(flag_c), 32'(e.fc));
      chk("flag_z", e.id, 32'(flag_z), 32'(e.fz));
    end
  end

  task automatic clr();
    reset = 1'b0; stall = 1'b0;
    ID_EX_A = '0; ID_EX_B = '0; ID_EX_instruction = '0;
    ID_EX_mem_write = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_alu_use_carry = 1'b0;
    ID_EX_alu_B_mux = 1'b0; ID_EX_select_c = 1'b0; ID_EX_select_z = 1'b0;
    ID_EX_write_c = 1'b0; ID_EX_write_z = 1'b0; ID_EX_alu_op = '0;
    ID_EX_reg_write_mux = '0;
    MEM_WB_reg_write = 1'b0; MEM_WB_dest = '0; MEM_WB_data = '0;
  endtask

  // One clock: build expectation (reset -> zeros, stall -> hold), push it
  // after the edge, then move inputs just past the following negedge.
  task automatic step(input logic [7:0] r, input logic [7:0] bb, input logic c,
                      input logic z);
    exp_t e;
    vec_id++;
    e.id = vec_id;
    if (reset) begin
      e.res = '0; e.b = '0; e.instr = '0; e.dest = '0; e.ctl = '0;
      e.fc = 1'b0; e.fz = 1'b0;
    end else if (stall) begin
      e = last;
      e.id = vec_id;
    end else begin
      e.res   = r;
      e.b     = bb;
      e.instr = ID_EX_instruction;
      e.dest  = ID_EX_instruction[13:11];
      e.ctl   = {ID_EX_mem_write, ID_EX_reg_write, ID_EX_select_c, ID_EX_select_z,
                 ID_EX_reg_write_mux};
      e.fc    = c;
      e.fz    = z;
    end
    @(posedge clk);
    q.push_back(e);
    last = e;
    @(negedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    ID_EX_A = 8'($urandom); ID_EX_B = 8'($urandom);
    ID_EX_instruction = 19'($urandom);
    ID_EX_mem_write = 1'($urandom); ID_EX_reg_write = 1'($urandom);
    ID_EX_alu_use_carry = 1'($urandom); ID_EX_alu_B_mux = 1'($urandom);
    ID_EX_select_c = 1'($urandom); ID_EX_select_z = 1'($urandom);
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    ID_EX_alu_op = 3'($urandom); ID_EX_reg_write_mux = 2'($urandom);
    MEM_WB_reg_write = 1'($urandom); MEM_WB_dest = 3'($urandom);
    MEM_WB_data = 8'($urandom);
  endtask

  initial begin
    clr();
    @(negedge clk);
    #1;

    // Reset with random inputs, then reset together with stall.
    randomize_inputs(); reset = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b0);
    randomize_inputs(); reset = 1'b1; stall = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // ADD F0+20 -> 10, carry out.
    clr(); ID_EX_A = 8'hF0; ID_EX_B = 8'h20; ID_EX_instruction = mk(3'd1, 3'd1, 8'h40);
    ID_EX_reg_write = 1'b1; ID_EX_mem_write = 1'b1;
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h10, 8'h20, 1'b1, 1'b0);
    // ADC back-to-back: 1+1+carry -> 3.
    clr(); ID_EX_A = 8'h01; ID_EX_B = 8'h01; ID_EX_instruction = mk(3'd2, 3'd4, 8'hA0);
    ID_EX_reg_write = 1'b1; ID_EX_alu_use_carry = 1'b1;
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h03, 8'h01, 1'b0, 1'b0);

    // SUB immediate to zero; EX_MEM_B keeps register B, not imm.
    clr(); ID_EX_A = 8'h05; ID_EX_B = 8'h77; ID_EX_instruction = mk(3'd5, 3'd4, 8'h05);
    ID_EX_alu_op = 3'b001; ID_EX_alu_B_mux = 1'b1;
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h00, 8'h77, 1'b0, 1'b1);
    // Nonzero SUB with write_z=0: Z must stay 1.
    clr(); ID_EX_A = 8'h06; ID_EX_B = 8'h77; ID_EX_instruction = mk(3'd5, 3'd4, 8'h05);
    ID_EX_alu_op = 3'b001; ID_EX_alu_B_mux = 1'b1; ID_EX_write_c = 1'b1;
    step(8'h01, 8'h77, 1'b0, 1'b1);

    // PASS imm 11 into r3 (ALU writeback).
    clr(); ID_EX_instruction = mk(3'd3, 3'd0, 8'h11); ID_EX_alu_op = 3'b111;
    ID_EX_alu_B_mux = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_select_c = 1'b1;
    step(8'h11, 8'h00, 1'b0, 1'b1);
    // ADD r3+B while MEM/WB also writes r3=22: EX/MEM 11 wins -> 12.
    clr(); ID_EX_A = 8'h00; ID_EX_B = 8'h01; ID_EX_instruction = mk(3'd6, 3'd3, 8'hA0);
    MEM_WB_reg_write = 1'b1; MEM_WB_dest = 3'd3; MEM_WB_data = 8'h22;
    ID_EX_select_z = 1'b1;
    step(8'h12, 8'h01, 1'b0, 1'b1);
    // Load into r3 (mux=01).
    clr(); ID_EX_instruction = mk(3'd3, 3'd0, 8'h44); ID_EX_alu_op = 3'b111;
    ID_EX_alu_B_mux = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_reg_write_mux = 2'b01;
    step(8'h44, 8'h00, 1'b0, 1'b1);
    // Load in EX/MEM is not forwarded: MEM/WB 22 used -> 23.
    clr(); ID_EX_A = 8'h00; ID_EX_B = 8'h01; ID_EX_instruction = mk(3'd6, 3'd3, 8'hA0);
    MEM_WB_reg_write = 1'b1; MEM_WB_dest = 3'd3; MEM_WB_data = 8'h22;
    step(8'h23, 8'h01, 1'b0, 1'b1);

    // Stall three cycles with a flag-writing ADD presented, then release.
    clr(); ID_EX_A = 8'h10; ID_EX_B = 8'h20; ID_EX_instruction = mk(3'd4, 3'd5, 8'hC0);
    ID_EX_reg_write = 1'b1; ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0);
    stall = 1'b0;
    step(8'h30, 8'h20, 1'b0, 1'b0);
    // Bubble: zero result registers, flags untouched.
    clr();
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // SHL 81 -> 02, C=1; then SHR 02 with carry in -> 81, C=0.
    clr(); ID_EX_A = 8'h81; ID_EX_instruction = mk(3'd1, 3'd1, 8'h40);
    ID_EX_alu_op = 3'b101; ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h02, 8'h00, 1'b1, 1'b0);
    clr(); ID_EX_A = 8'h02; ID_EX_instruction = mk(3'd1, 3'd1, 8'h40);
    ID_EX_alu_op = 3'b110; ID_EX_alu_use_carry = 1'b1;
    ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h81, 8'h00, 1'b0, 1'b0);

    // Reset mid-sequence discards the in-flight ADD.
    clr(); ID_EX_A = 8'h01; ID_EX_B = 8'h01; ID_EX_instruction = mk(3'd2, 3'd1, 8'h40);
    ID_EX_reg_write = 1'b1; ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1; reset = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // XOR to zero sets Z; OR clears it.
    clr(); ID_EX_A = 8'hFF; ID_EX_B = 8'hFF; ID_EX_instruction = mk(3'd2, 3'd1, 8'h40);
    ID_EX_alu_op = 3'b100; ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    clr(); ID_EX_A = 8'h0F; ID_EX_B = 8'hF0; ID_EX_instruction = mk(3'd2, 3'd1, 8'h40);
    ID_EX_alu_op = 3'b011; ID_EX_write_c = 1'b1; ID_EX_write_z = 1'b1;
    step(8'hFF, 8'hF0, 1'b0, 1'b0);

    clr();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register of the 8-bit pipelined core. Consumes the ID/EX pipeline outputs and resolves A/B operands through EX/MEM and MEM/WB forwarding. Runs the 8-bit ALU, owns the architectural carry (C) and zero (Z) flag registers, and registers the ALU result and control for the memory stage.

Parameters:
DATA_W, 8, datapath width (flags and shift rules assume 8)
INSTR_W, 19, instruction word width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stall  in  1  hold EX/MEM register and flags
ID_EX_A  in  8  register operand A
ID_EX_B  in  8  register operand B
ID_EX_instruction  in  19  instruction word; dest=[13:11], srcA=[10:8], srcB=[7:5], imm=[7:0]
ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry, ID_EX_alu_B_mux  in  1 each  control
ID_EX_select_c, ID_EX_select_z, ID_EX_write_c, ID_EX_write_z  in  1 each  control
ID_EX_alu_op  in  3  ALU operation
ID_EX_reg_write_mux  in  2  writeback source (00 ALU, 01 memory, 10 immediate, 11 reserved)
MEM_WB_reg_write  in  1  writeback enable of the instruction in WB
MEM_WB_dest  in  3  WB destination register
MEM_WB_data  in  8  WB data
EX_MEM_alu_result  out  8  registered ALU result
EX_MEM_B  out  8  registered forwarded B (store data)
EX_MEM_instruction  out  19  registered instruction
EX_MEM_dest  out  3  registered instruction[13:11]
EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_select_c, EX_MEM_select_z  out  1 each  registered control
EX_MEM_reg_write_mux  out  2  registered writeback select
flag_c  out  1  carry flag register
flag_z  out  1  zero flag register

Behaviour:
- Clock and reset: all state updates on rising clk. reset (synchronous, active-high) clears every output register and both flags to 0, and has priority over stall. A reset asserted mid-sequence discards the in-flight instruction.
- Forwarding for A (compare srcA) and B (compare srcB):
  - First priority: EX_MEM_reg_write=1 and EX_MEM_reg_write_mux=00 and EX_MEM_dest matches -> use EX_MEM_alu_result.
  - Second priority: MEM_WB_reg_write=1 and MEM_WB_dest matches -> use MEM_WB_data.
  - Otherwise use the ID_EX operand.
  - A load in EX/MEM (mux=01) is never forwarded from EX/MEM; load-use stalls are upstream's job.
  - Register 0 is forwarded like any other register.
- ALU operand B: alu_B_mux=0 -> forwarded B; 1 -> imm. EX_MEM_B always carries forwarded B, not imm.
- Carry-in: cin = alu_use_carry & flag_c.
- alu_op, 9-bit internal arithmetic:
  - 000 ADD: A+B+cin; C=bit8.
  - 001 SUB: A-B-cin; C=1 on borrow.
  - 010 AND, 011 OR, 100 XOR: C=0.
  - 101 SHL: A<<1, bit0=cin; C=A[7].
  - 110 SHR: A>>1, bit7=cin; C=A[0].
  - 111 PASS: result=opB; C=0.
- Z = (result==8'h00).
- Flags: flag_c updates only when write_c=1 and neither stall nor reset is active; flag_z likewise with write_z. Flags are visible to the very next instruction in EX, so back-to-back ADC has no hazard.
- Pipeline register: latency 1 cycle from the ID/EX inputs to the EX_MEM_* outputs. When stall=1, all EX_MEM_* outputs and flags hold; forwarding still uses the held EX/MEM values.
- Bubble (all-zero control from an upstream flush): no register write, no memory write, no flag change. The zero ALU result still registers and is harmless.
- select_c/select_z pass through unmodified for the downstream branch logic.

Test Plan:
- Reset: drive reset=1 with random inputs, one clk -> all EX_MEM_* outputs=0, flag_c=0, flag_z=0; assert reset and stall together -> still all 0.
- ADC chain: ADD A=8'hF0, B=8'h20, write_c=1, write_z=1 -> result 8'h10, flag_c=1, flag_z=0. Next cycle ADD with use_carry, A=8'h01, B=8'h01 -> result 8'h03.
- SUB to zero: A=8'h05, imm=8'h05, alu_B_mux=1, write_z=1 -> result 8'h00, flag_z=1, flag_c=0. Same op with write_z=0 -> flag_z unchanged.
- Forward priority: EX/MEM writes r3=8'h11 (mux=00) while MEM/WB writes r3=8'h22, and EX instruction ADD srcA=r3, ID_EX_A=8'h00, B=8'h01 -> result 8'h12. With the EX/MEM mux=01 instead -> result 8'h23.
- Stall: hold stall=1 for 3 cycles with a flag-writing ADD presented -> outputs and flags frozen. Release -> ADD commits exactly once.
- Shifts: SHL A=8'h81, cin=0 -> 8'h02, C=1. Then SHR A=8'h02 with use_carry -> 8'h81, C=0.
